// File: rtl/methane_link_pkg.sv
// Shared definitions for the methane serial link: FSM state encoding, default
// sync pattern and idle line level. Reused by the transmitter, detector and benches.
package methane_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } link_state_e;

  localparam int                   DEF_PAT_W    = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN  = 8'b0011_0101;
  localparam logic                 DEF_IDLE_BIT = 1'b0;

  // Largest count any phase needs, never below 2 so the counter is at least 1 bit.
  function automatic int cnt_span(input int pat_w, input int data_w, input int gap_bits);
    int m;
    m = 2;
    if (pat_w > m) m = pat_w;
    if (data_w > m) m = data_w;
    if (gap_bits > m) m = gap_bits;
    return m;
  endfunction

endpackage

// File: rtl/methane_shift_out.sv
// Loadable shift register presenting its MSB; each shift moves the next payload
// bit into the MSB position.
module methane_shift_out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              shift_i,
  output logic              msb_o
);

  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      sh_d = sh_q << 1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_o = sh_q[DATA_W-1];

endmodule

// File: rtl/methane_pattern_tx.sv
// Serial frame transmitter: sync pattern, payload and idle gap, all MSB first.
// Handshake: a word transfers on a rising edge where in_valid and in_ready are both high.
module methane_pattern_tx
  import methane_link_pkg::*;
#(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN  = DEF_PATTERN,
  parameter int               DATA_W   = 8,
  parameter int               GAP_BITS = 2,
  parameter logic             IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_start,
  output link_state_e       dbg_state
);

  localparam int CNT_W = $clog2(cnt_span(PAT_W, DATA_W, GAP_BITS));
  localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             fs_q, fs_d;
  logic             load, shift, sh_msb, accept;

  methane_shift_out #(.DATA_W(DATA_W)) u_shift (
    .clk    (clk),
    .arst_n (arst_n),
    .load_i (load),
    .data_i (in_data),
    .shift_i(shift),
    .msb_o  (sh_msb)
  );

  assign accept = in_valid & in_ready;

  // dout_d is the bit the line carries during the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = IDLE_BIT;
    fs_d    = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SYNC;
          cnt_d   = PAT_LAST;
          dout_d  = PATTERN[PAT_W-1];
          fs_d    = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LAST;
          dout_d  = sh_msb;
          shift   = 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          dout_d = PATTERN[cnt_d];
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = GAP_LAST;
          if (GAP_BITS == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d  = cnt_q - 1'b1;
          dout_d = sh_msb;
          shift  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= IDLE_BIT;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      fs_q    <= fs_d;
    end
  end

  // Gating with arst_n keeps in_ready low for the whole time reset is asserted.
  assign in_ready    = arst_n & (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign dout        = dout_q;
  assign frame_start = fs_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_methane_pattern_tx.sv
// Bench for methane_pattern_tx: a default instance (8-bit payload, 2 gap bits)
// and a corner instance (1-bit payload, no gap), checked against a frame model.
module tb_methane_pattern_tx;
  import methane_link_pkg::*;

  localparam logic [7:0] PAT = 8'b0011_0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic        in_valid_a, in_ready_a, dout_a, busy_a, fs_a;
  logic [7:0]  in_data_a;
  link_state_e st_a;
  logic        in_valid_b, in_ready_b, dout_b, busy_b, fs_b;
  logic [0:0]  in_data_b;
  link_state_e st_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];
  logic [0:0] obs_q[$];
  bit         mon_en = 1'b0;

  methane_pattern_tx dut_a (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .dout(dout_a), .busy(busy_a), .frame_start(fs_a),
    .dbg_state(st_a)
  );

  methane_pattern_tx #(.DATA_W(1), .GAP_BITS(0)) dut_b (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .dout(dout_b), .busy(busy_b), .frame_start(fs_b),
    .dbg_state(st_b)
  );

  always @(negedge clk) if (mon_en) obs_q.push_back(dout_a);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference frame: sync pattern, payload, two idle gap bits, all MSB first.
  task automatic push_frame(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) exp_q.push_back(PAT[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
  endtask

  // Positions (index of last bit) where the 8-bit sync pattern ends in a stream.
  task automatic find_hits(input logic [0:0] s[$], output int hits[$]);
    logic [7:0] win;
    win = '0;
    hits.delete();
    for (int i = 0; i < s.size(); i++) begin
      win = {win[6:0], s[i]};
      if (i >= 7 && win == PAT) hits.push_back(i);
    end
  endtask

  task automatic send_check(input logic [7:0] d, input bit scramble, output logic [17:0] word);
    int   busy_cnt;
    logic exp_bit;
    busy_cnt = 0;
    word = '0;
    exp_q.delete();
    push_frame(d);
    @(posedge clk); #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_errors++; $display("FAIL ready_before_send: got %b want 1", in_ready_a);
    end
    in_valid_a = 1'b1; in_data_a = d;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      if (i < 18) word = {word[16:0], dout_a};
      n_checks++;
      if (dout_a !== exp_bit) begin
        n_errors++; $display("FAIL dout bit %0d (data %h): got %b want %b", i, d, dout_a, exp_bit);
      end
      n_checks++;
      if (fs_a !== (i == 0)) begin
        n_errors++; $display("FAIL frame_start cycle %0d: got %b want %b", i, fs_a, (i == 0));
      end
      if (busy_a === 1'b1) busy_cnt++;
      if (scramble) in_data_a = 8'($urandom);
    end
    n_checks++;
    if (busy_cnt != 18) begin
      n_errors++; $display("FAIL busy_length: got %0d want 18", busy_cnt);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0;
    in_valid_b = 1'b0; in_data_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dout_a, busy_a, in_ready_a, fs_a} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_outputs: got %b want 0000", {dout_a, busy_a, in_ready_a, fs_a});
    end
    @(posedge clk); #2 arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      n_errors++; $display("FAIL ready_after_release: got %b%b want 11", in_ready_a, in_ready_b);
    end
    // Start an all-ones frame and abort it partway through the payload.
    @(posedge clk); #1 in_valid_a = 1'b1; in_data_a = 8'hFF;
    @(posedge clk); #1 in_valid_a = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, dout_a} !== 2'b11) begin
      n_errors++; $display("FAIL mid_data_before_abort: got busy,dout=%b want 11", {busy_a, dout_a});
    end
    #1 arst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout_a, busy_a, in_ready_a, fs_a} !== 4'b0000) begin
      n_errors++; $display("FAIL abort_outputs: got %b want 0000", {dout_a, busy_a, in_ready_a, fs_a});
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dout_a, busy_a, in_ready_a, fs_a} !== 4'b0010) begin
        n_errors++; $display("FAIL no_tail cycle %0d: got %b want 0010", i, {dout_a, busy_a, in_ready_a, fs_a});
      end
    end
  endtask

  task automatic test_single();
    logic [17:0] word;
    send_check(8'hA5, 1'b0, word);
    n_checks++;
    if (word !== 18'b001101011010010100) begin
      n_errors++; $display("FAIL single_stream: got %b want 001101011010010100", word);
    end
  endtask

  task automatic test_data_ignored();
    logic [17:0] word;
    logic [7:0]  d;
    for (int f = 0; f < 3; f++) begin
      d = 8'($urandom);
      send_check(d, 1'b1, word);
      n_checks++;
      if (word[9:2] !== d) begin
        n_errors++; $display("FAIL latched_payload: got %h want %h", word[9:2], d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   fs1, fs2, n_fs, ready_between;
    logic exp_bit;
    fs1 = -1; fs2 = -1; n_fs = 0; ready_between = 0;
    exp_q.delete();
    push_frame(8'hFF);
    exp_q.push_back(1'b0);
    push_frame(8'h00);
    @(posedge clk); #1 in_valid_a = 1'b1; in_data_a = 8'hFF;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (fs_a === 1'b1) begin
        n_fs++;
        if (fs1 < 0) fs1 = cyc;
        else if (fs2 < 0) fs2 = cyc;
      end
      if (fs1 >= 0 && fs2 < 0 && in_ready_a === 1'b1) ready_between++;
      if (fs1 >= 0 && exp_q.size() > 0) begin
        exp_bit = exp_q.pop_front();
        n_checks++;
        if (dout_a !== exp_bit) begin
          n_errors++; $display("FAIL b2b_dout cycle %0d: got %b want %b", cyc, dout_a, exp_bit);
        end
      end
      if (fs1 >= 0) in_data_a = 8'h00;
      if (fs2 >= 0) in_valid_a = 1'b0;
    end
    in_valid_a = 1'b0;
    n_checks++;
    if (fs1 < 0 || fs2 < 0 || (fs2 - fs1) != 19) begin
      n_errors++; $display("FAIL b2b_spacing: got fs1=%0d fs2=%0d want spacing 19", fs1, fs2);
    end
    n_checks++;
    if (ready_between != 1) begin
      n_errors++; $display("FAIL b2b_ready_pulses: got %0d want 1", ready_between);
    end
    n_checks++;
    if (n_fs != 2) begin
      n_errors++; $display("FAIL b2b_frame_count: got %0d want 2", n_fs);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL b2b_stream_len: got %0d bits left want 0", exp_q.size());
    end
  endtask

  task automatic test_corner();
    int   busy_cnt;
    logic exp_bit;
    busy_cnt = 0;
    @(posedge clk); #1 in_valid_b = 1'b1; in_data_b = 1'b1;
    @(posedge clk); #1 in_valid_b = 1'b0; in_data_b = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      exp_bit = (i < 8) ? PAT[7-i] : ((i == 8) ? 1'b1 : 1'b0);
      n_checks++;
      if (dout_b !== exp_bit) begin
        n_errors++; $display("FAIL corner_dout bit %0d: got %b want %b", i, dout_b, exp_bit);
      end
      n_checks++;
      if (fs_b !== (i == 0) || in_ready_b !== (i >= 9)) begin
        n_errors++; $display("FAIL corner_ctrl cycle %0d: got fs,ready=%b%b want %b%b",
                             i, fs_b, in_ready_b, (i == 0), (i >= 9));
      end
      if (busy_b === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 9) begin
      n_errors++; $display("FAIL corner_busy_length: got %0d want 9", busy_cnt);
    end
  endtask

  task automatic test_loopback();
    int         sync_end[$];
    int         exp_hits[$];
    int         obs_hits[$];
    int         pos, k;
    logic [7:0] d;
    bit         found;
    exp_q.delete(); obs_q.delete();
    pos = 0;
    @(posedge clk); #1 mon_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      k = $urandom_range(0, 3);
      d = (f == 0) ? PAT : 8'($urandom);
      repeat (k) begin @(posedge clk); #1; end
      in_valid_a = 1'b1; in_data_a = d;
      @(posedge clk); #1 in_valid_a = 1'b0;
      // k idle cycles plus the acceptance cycle, then the 18-bit frame.
      for (int j = 0; j <= k; j++) exp_q.push_back(1'b0);
      pos += k + 1;
      sync_end.push_back(pos + 7);
      push_frame(d);
      pos += 18;
      repeat (18) @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL loop_len: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL loop_bit %0d: got %b want %b", i, obs_q[i], exp_q[i]);
        end
      end
    end
    find_hits(exp_q, exp_hits);
    find_hits(obs_q, obs_hits);
    n_checks++;
    if (obs_hits.size() != exp_hits.size()) begin
      n_errors++; $display("FAIL loop_hit_count: got %0d want %0d", obs_hits.size(), exp_hits.size());
    end else begin
      for (int i = 0; i < exp_hits.size(); i++) begin
        n_checks++;
        if (obs_hits[i] != exp_hits[i]) begin
          n_errors++; $display("FAIL loop_hit %0d: got index %0d want %0d", i, obs_hits[i], exp_hits[i]);
        end
      end
    end
    foreach (sync_end[f]) begin
      found = 1'b0;
      foreach (obs_hits[h]) if (obs_hits[h] == sync_end[f]) found = 1'b1;
      n_checks++;
      if (!found) begin
        n_errors++; $display("FAIL loop_sync_hit frame %0d: got no hit want hit at %0d", f, sync_end[f]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_data_ignored();
    test_back_to_back();
    test_corner();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
